// File: rtl/rf_wb_pkg.sv
// Shared widths and the queued write-back record for the integer register file writer.
package rf_wb_pkg;

  localparam int unsigned WB_XLEN  = 64;
  localparam int unsigned WB_AW    = 5;
  localparam int unsigned WB_DEPTH = 4;

  typedef struct packed {
    logic [WB_AW-1:0]   rd;
    logic [WB_XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_entry_fifo.sv
// In-order circular buffer of pending write-backs; exposes its live entries oldest-first
// so the forwarding search can resolve age without knowing the pointer positions.
module wb_entry_fifo
  import rf_wb_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_push,
  input  wb_entry_t                   i_entry,
  input  logic                        i_pop,
  output wb_entry_t                   o_head,
  output logic [$clog2(DEPTH):0]      o_count,
  output wb_entry_t [DEPTH-1:0]       o_entries,
  output logic [DEPTH-1:0]            o_valid
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW:0]           r_count;
  wb_entry_t [DEPTH-1:0] r_mem;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_entry;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_comb begin
    o_entries = '0;
    o_valid   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_entries[i] = r_mem[r_rd_ptr + PW'(i)];
      o_valid[i]   = (i < int'(r_count));
    end
  end

endmodule

// File: rtl/regfile_writeback_queue.sv
// Register file writer: arbitrates load/ALU results into an in-order queue, drains one per
// cycle to the write port, and forwards the youngest pending value for both read addresses.
module regfile_writeback_queue
  import rf_wb_pkg::*;
#(
  parameter int unsigned XLEN  = WB_XLEN,
  parameter int unsigned DEPTH = WB_DEPTH,
  parameter int unsigned AW    = WB_AW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_valid,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            hold,
  output logic            RegWrite,
  output logic [AW-1:0]   RD,
  output logic [XLEN-1:0] WriteData,
  input  logic [AW-1:0]   RS1,
  input  logic [AW-1:0]   RS2,
  output logic            fwd1_hit,
  output logic [XLEN-1:0] fwd1_data,
  output logic            fwd2_hit,
  output logic [XLEN-1:0] fwd2_data,
  output logic [AW-1:0]   occupancy
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]         w_count;
  wb_entry_t             w_head;
  wb_entry_t [DEPTH-1:0] w_entries;
  logic [DEPTH-1:0]      w_valid;
  wb_entry_t             w_push_entry;
  logic                  w_space;
  logic                  w_take_mem;
  logic                  w_take_alu;
  logic                  w_push;
  logic                  w_pop;

  logic                  r_reg_write;
  logic [AW-1:0]         r_rd;
  logic [XLEN-1:0]       r_wdata;

  // Space comes from the registered count only: a same-cycle pop gives no credit.
  assign w_space    = (w_count < CW'(DEPTH));
  assign mem_ready  = w_space & ~reset;
  assign alu_ready  = w_space & ~mem_valid & ~reset;
  assign w_take_mem = mem_valid & mem_ready;
  assign w_take_alu = alu_valid & alu_ready;

  assign w_push_entry = w_take_mem ? wb_entry_t'{rd: mem_rd, data: mem_data}
                                   : wb_entry_t'{rd: alu_rd, data: alu_data};
  // Writes to x0 are acknowledged but dropped.
  assign w_push = (w_take_mem | w_take_alu) & (w_push_entry.rd != '0);
  assign w_pop  = (w_count != '0) & ~hold;

  wb_entry_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_push    (w_push),
    .i_entry   (w_push_entry),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_count   (w_count),
    .o_entries (w_entries),
    .o_valid   (w_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_wdata     <= '0;
    end else if (w_pop) begin
      r_reg_write <= 1'b1;
      r_rd        <= w_head.rd;
      r_wdata     <= w_head.data;
    end else begin
      r_reg_write <= 1'b0;
    end
  end

  assign RegWrite  = r_reg_write;
  assign RD        = r_rd;
  assign WriteData = r_wdata;
  assign occupancy = AW'(w_count);

  // Scan oldest to youngest (output register first, then queue head onward) so the last hit wins.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    if (r_reg_write && (r_rd == RS1) && (RS1 != '0)) begin
      fwd1_hit  = 1'b1;
      fwd1_data = r_wdata;
    end
    if (r_reg_write && (r_rd == RS2) && (RS2 != '0)) begin
      fwd2_hit  = 1'b1;
      fwd2_data = r_wdata;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i] && (w_entries[i].rd == RS1) && (RS1 != '0)) begin
        fwd1_hit  = 1'b1;
        fwd1_data = w_entries[i].data;
      end
      if (w_valid[i] && (w_entries[i].rd == RS2) && (RS2 != '0)) begin
        fwd2_hit  = 1'b1;
        fwd2_data = w_entries[i].data;
      end
    end
  end

endmodule
